bin_to_bcd_tube: RTL and testbench

Sequential binary-to-BCD converter placed directly upstream of the seven-segment tube driver. It accepts a 32-bit unsigned value from the CPU's I/O path and converts it to eight packed BCD digits using shift-add-3 (double dabble), one bit per clock. It presents the result as a 32-bit word plus a one-cycle `done` strobe that feeds the tube driver's latch-enable, so the display shows decimal instead of hex.

---
 rtl/bin_to_bcd_tube.sv | 115 +++++++++++
 tb/tb_bin_to_bcd_tube.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_tube.sv
// Sequential 32-bit binary to packed BCD converter (shift-add-3, one bit per clock)
// feeding the seven-segment tube driver; done strobes the driver's latch-enable.
//
// state  | meaning
// IDLE   | waiting for start; bcd_out/overflow hold the last result
// SHIFT  | one add-3 + shift step per cycle, BIN_WIDTH steps
// FINISH | range check, load bcd_out/overflow, pulse done
module bin_to_bcd_tube #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  // two spare digits so any 32-bit value fits before the range check
  localparam int SCR_DIGITS = DIGITS + 2;
  localparam int SCR_W      = 4 * SCR_DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [SCR_W-1:0]     scratch;
  logic [SCR_W-1:0]     scratch_adj;
  logic [5:0]           cnt;
  logic                 last_step;
  logic                 fits;

  assign last_step = (cnt == 6'(BIN_WIDTH - 1));
  assign fits      = (scratch[SCR_W-1:4*DIGITS] == '0);

  // per-digit add-3, no carry between digits
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < SCR_DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bin_sr   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          {scratch, bin_sr} <= {scratch_adj[SCR_W-2:0], bin_sr, 1'b0};
          if (!last_step) begin
            cnt <= cnt + 6'd1;
          end
        end
        FINISH: begin
          done <= 1'b1;
          if (fits) begin
            bcd_out  <= scratch[4*DIGITS-1:0];
            overflow <= 1'b0;
          end else begin
            bcd_out  <= {DIGITS{4'hE}};
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_tube.sv
// Self-checking bench for bin_to_bcd_tube: scoreboard of expected results from a
// divide-by-ten reference, popped and compared whenever done pulses.
module tb_bin_to_bcd_tube;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic        overflow;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   overlap = 0;

  bin_to_bcd_tube #(.BIN_WIDTH(32), .DIGITS(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (busy && done) overlap++;
  end

  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    logic [31:0] r;
    r = v;
    e.bcd = 32'h0;
    e.ovf = 1'b0;
    if (v > 32'd99999999) begin
      e.bcd = 32'hEEEE_EEEE;
      e.ovf = 1'b1;
    end else begin
      for (int d = 0; d < 8; d++) begin
        e.bcd[4*d +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
    return e;
  endfunction

  // one-cycle start pulse; acc is the number of the accepting edge
  task automatic pulse(input logic [31:0] v, output int acc);
    @(negedge clock);
    bin_in = v;
    start  = 1'b1;
    acc    = cyc + 1;
    sb.push_back(model(v));
    @(negedge clock);
    start = 1'b0;
  endtask

  // samples from the current negedge until done; no comparisons here
  task automatic wait_done(output int edge_n, output int busy_n, output bit ok);
    ok = 1'b0;
    busy_n = 0;
    edge_n = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) busy_n++;
      if (done) begin
        ok = 1'b1;
        edge_n = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    start  = 1'b0;
    bin_in = 32'h0;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (bcd_out !== 32'h0) $display("FAIL reset_bcd: got %h want 00000000", bcd_out); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passed++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_zero;
    int acc, edge_n, busy_n;
    bit ok;
    exp_t e;
    pulse(32'd0, acc);
    wait_done(edge_n, busy_n, ok);
    total++; if (!ok) $display("FAIL zero_timeout: got no done want done"); else passed++;
    if (sb.size() > 0) e = sb.pop_front();
    total++; if (busy_n !== 33) $display("FAIL zero_busy_cycles: got %0d want 33", busy_n); else passed++;
    total++; if (bcd_out !== e.bcd || overflow !== e.ovf)
      $display("FAIL zero_result: got %h/%b want %h/%b", bcd_out, overflow, e.bcd, e.ovf); else passed++;
    @(negedge clock);
    total++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else passed++;
  endtask

  task automatic test_values;
    logic [31:0] vals [4];
    int acc, edge_n, busy_n;
    bit ok;
    exp_t e;
    vals[0] = 32'd12345678;
    vals[1] = 32'd99999999;
    vals[2] = 32'd100000000;
    vals[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      pulse(vals[i], acc);
      wait_done(edge_n, busy_n, ok);
      if (sb.size() > 0) e = sb.pop_front();
      total++; if (!ok || edge_n - acc != 33)
        $display("FAIL val%0d_latency: got %0d want 33", i, edge_n - acc); else passed++;
      total++; if (bcd_out !== e.bcd) $display("FAIL val%0d_bcd: got %h want %h", i, bcd_out, e.bcd); else passed++;
      total++; if (overflow !== e.ovf) $display("FAIL val%0d_ovf: got %b want %b", i, overflow, e.ovf); else passed++;
    end
    total++; if (bcd_out !== 32'hEEEE_EEEE)
      $display("FAIL max_error_pattern: got %h want eeeeeeee", bcd_out); else passed++;
  endtask

  task automatic test_ignored_start;
    int acc, edge_n, busy_n, d0;
    bit ok;
    exp_t e;
    pulse(32'd42, acc);
    repeat (9) @(negedge clock);
    bin_in = 32'd7;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    d0 = done_cnt;
    wait_done(edge_n, busy_n, ok);
    if (sb.size() > 0) e = sb.pop_front();
    total++; if (!ok || bcd_out !== e.bcd)
      $display("FAIL ignored_result: got %h want %h", bcd_out, e.bcd); else passed++;
    total++; if (!ok || edge_n - acc != 33)
      $display("FAIL ignored_latency: got %0d want 33", edge_n - acc); else passed++;
    repeat (45) @(negedge clock);
    total++; if (done_cnt - d0 !== 1)
      $display("FAIL ignored_single_done: got %0d want 1", done_cnt - d0); else passed++;
  endtask

  task automatic test_back_to_back;
    int edge1, edge2, busy_n;
    bit ok1, ok2;
    exp_t e1, e2;
    @(negedge clock);
    bin_in = 32'd5;
    start  = 1'b1;
    sb.push_back(model(32'd5));
    sb.push_back(model(32'd1000));
    @(negedge clock);
    bin_in = 32'd1000;
    wait_done(edge1, busy_n, ok1);
    if (sb.size() > 0) e1 = sb.pop_front();
    total++; if (!ok1 || bcd_out !== e1.bcd)
      $display("FAIL b2b_first: got %h want %h", bcd_out, e1.bcd); else passed++;
    @(negedge clock);
    wait_done(edge2, busy_n, ok2);
    start = 1'b0;
    if (sb.size() > 0) e2 = sb.pop_front();
    total++; if (!ok2 || bcd_out !== e2.bcd)
      $display("FAIL b2b_second: got %h want %h", bcd_out, e2.bcd); else passed++;
    total++; if (!ok1 || !ok2 || edge2 - edge1 != 34)
      $display("FAIL b2b_spacing: got %0d want 34", edge2 - edge1); else passed++;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_abort;
    int acc, edge_n, busy_n, d0;
    bit ok;
    exp_t e;
    pulse(32'd777, acc);
    void'(sb.pop_back());
    repeat (13) @(negedge clock);
    reset = 1'b0;
    d0 = done_cnt;
    @(negedge clock);
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (bcd_out !== 32'h0) $display("FAIL abort_bcd: got %h want 00000000", bcd_out); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL abort_ovf: got %b want 0", overflow); else passed++;
    reset = 1'b1;
    repeat (40) @(negedge clock);
    total++; if (done_cnt !== d0) $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); else passed++;
    pulse(32'd777, acc);
    wait_done(edge_n, busy_n, ok);
    if (sb.size() > 0) e = sb.pop_front();
    total++; if (!ok || bcd_out !== e.bcd || overflow !== e.ovf)
      $display("FAIL abort_recover: got %h/%b want %h/%b", bcd_out, overflow, e.bcd, e.ovf); else passed++;
    total++; if (!ok || edge_n - acc != 33)
      $display("FAIL abort_recover_latency: got %0d want 33", edge_n - acc); else passed++;
  endtask

  task automatic test_exclusive;
    total++; if (overlap !== 0) $display("FAIL busy_done_overlap: got %0d want 0", overlap); else passed++;
    total++; if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_exclusive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
